// File: rtl/fnet_if.sv
// Block/key handshake bundle for the iterative GOST Feistel core.
// Slave side faces the core; master side faces the block-mode controller.
interface fnet_if;
  logic         in_valid;
  logic         in_ready;
  logic [63:0]  in_data;
  logic [255:0] key;
  logic         decrypt;
  logic         out_valid;
  logic         out_ready;
  logic [63:0]  out_data;
  logic         busy;

  modport master (
    output in_valid, in_data, key, decrypt, out_ready,
    input  in_ready, out_valid, out_data, busy
  );

  modport slave (
    input  in_valid, in_data, key, decrypt, out_ready,
    output in_ready, out_valid, out_data, busy
  );
endinterface

// File: rtl/fnet_iter.sv
// Iterative GOST 28147-89 Feistel network, UNROLL rounds per clock.
// fcell: one round function, 8x4-bit S-box substitution then rotl 11.
module fcell (
  input  logic [31:0] x,
  output logic [31:0] y
);
  // Row j substitutes nibble j; entry v sits at bits [4v+3:4v].
  localparam logic [63:0] SB [8] = '{
    64'h35F7C1B6E08D29A4,
    64'h95701832AFD6C4BE,
    64'hB9067CFE243AD185,
    64'h352BC64EF9801AD7,
    64'h2B30E9A48DF517C6,
    64'hEFC95863D1270AB4,
    64'hC2867EA095F314BD,
    64'hC8B6E3294A750DF1
  };

  logic [31:0] s;

  // Per-nibble S-box lookup
  always_comb begin
    s = '0;
    for (int j = 0; j < 8; j++) begin
      s[4*j +: 4] = SB[j][{x[4*j +: 4], 2'b00} +: 4];
    end
  end

  assign y = {s[20:0], s[31:21]};
endmodule

module fnet_iter #(
  parameter int UNROLL = 1
) (
  input  logic   clk,
  input  logic   rst_n,
  fnet_if.slave  bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam logic [5:0] STEP = 6'(UNROLL);

  if (UNROLL != 1 && UNROLL != 2 && UNROLL != 4 &&
      UNROLL != 8 && UNROLL != 16 && UNROLL != 32) begin : g_bad
    $error("fnet_iter: UNROLL must be 1, 2, 4, 8, 16 or 32");
  end

  logic [1:0]   state;
  logic [5:0]   cnt;
  logic [31:0]  hi;
  logic [31:0]  lo;
  logic [255:0] key_q;
  logic         dec_q;
  logic [63:0]  out_q;

  logic [31:0]  h [UNROLL+1];
  logic [31:0]  l [UNROLL+1];
  logic [5:0]   cnt_n;
  logic         last;
  logic         run_st;
  logic         done_st;
  logic         cap;
  logic         drain;

  assign run_st  = state == RUN;
  assign done_st = state == DONE;
  assign cnt_n   = cnt + STEP;
  assign last    = cnt_n == 6'd32;

  assign bus.in_ready  = (state == IDLE) |
                         (done_st & bus.out_ready);
  assign bus.out_valid = done_st;
  assign bus.busy      = run_st;
  assign bus.out_data  = out_q;

  assign cap   = bus.in_valid & bus.in_ready;
  assign drain = done_st & bus.out_ready & ~bus.in_valid;

  assign h[0] = hi;
  assign l[0] = lo;

  // Combinational chain of UNROLL rounds from the current counter
  for (genvar u = 0; u < UNROLL; u++) begin : g_rnd
    logic [4:0]  r;
    logic [2:0]  idx;
    logic [31:0] sub;
    logic [31:0] sum;
    logic [31:0] f;

    assign r   = cnt[4:0] + 5'(u);
    assign idx = (dec_q ? (r < 5'd8) : (r < 5'd24)) ?
                 r[2:0] : ~r[2:0];
    assign sub = key_q[{idx, 5'd0} +: 32];
    assign sum = l[u] + sub;

    fcell u_fcell (
      .x (sum),
      .y (f)
    );

    assign h[u+1] = l[u];
    assign l[u+1] = h[u] ^ f;
  end

  // Control FSM plus data, key, mode and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      hi    <= '0;
      lo    <= '0;
      key_q <= '0;
      dec_q <= 1'b0;
      out_q <= '0;
    end else begin
      unique case (1'b1)
        run_st: begin
          hi  <= h[UNROLL];
          lo  <= l[UNROLL];
          cnt <= cnt_n;
          if (last) begin
            out_q <= {l[UNROLL], h[UNROLL]};
            state <= DONE;
          end
        end
        cap: begin
          hi    <= bus.in_data[63:32];
          lo    <= bus.in_data[31:0];
          key_q <= bus.key;
          dec_q <= bus.decrypt;
          cnt   <= '0;
          state <= RUN;
        end
        drain: begin
          state <= IDLE;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fnet_iter.sv
// Scoreboard bench for fnet_iter: driver queues expectations,
// an output monitor pops and compares on each handshake.
module tb_fnet_iter;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int chks = 0;
  int errs = 0;

  localparam int SBOX [8][16] = '{
    '{4,10,9,2,13,8,0,14,6,11,1,12,7,15,5,3},
    '{14,11,4,12,6,13,15,10,2,3,8,1,0,7,5,9},
    '{5,8,1,13,10,3,4,2,14,15,12,7,6,0,9,11},
    '{7,13,10,1,0,8,9,15,14,4,6,12,11,2,5,3},
    '{6,12,7,1,5,15,13,8,4,10,9,14,0,3,11,2},
    '{4,11,10,0,7,2,1,13,3,6,8,5,9,12,15,14},
    '{13,11,4,1,3,15,5,9,0,10,14,7,6,8,2,12},
    '{1,15,13,0,5,7,10,4,9,2,3,14,6,11,8,12}
  };
  localparam int UV [6] = '{1, 2, 4, 8, 16, 32};
  localparam logic [255:0] K0 =
    256'hffeeddccbbaa99887766554433221100f0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
  localparam logic [63:0] P0 = 64'hfedcba9876543210;

  fnet_if bus ();

  fnet_iter #(.UNROLL(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  logic         sw_valid;
  logic [63:0]  sw_in;
  logic [255:0] sw_key;
  logic         sw_dec;
  logic [5:0]   sw_ov;
  logic [5:0]   sw_rdy;
  logic [63:0]  sw_out [6];

  fnet_if sw_if [6] ();

  for (genvar g = 0; g < 6; g++) begin : g_sw
    assign sw_if[g].in_valid  = sw_valid;
    assign sw_if[g].in_data   = sw_in;
    assign sw_if[g].key       = sw_key;
    assign sw_if[g].decrypt   = sw_dec;
    assign sw_if[g].out_ready = 1'b1;
    assign sw_ov[g]  = sw_if[g].out_valid;
    assign sw_rdy[g] = sw_if[g].in_ready;
    assign sw_out[g] = sw_if[g].out_data;

    fnet_iter #(.UNROLL(UV[g])) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (sw_if[g].slave)
    );
  end

  typedef struct {
    logic [63:0] exp;
    int          cap;
  } sb_t;

  sb_t exp_q [$];

  task automatic chk(string name, logic [63:0] act,
                     logic [63:0] exp);
    chks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] f_ref(logic [31:0] x);
    logic [31:0] s;
    s = '0;
    for (int j = 0; j < 8; j++)
      s = s | (32'(SBOX[j][(x >> (4*j)) & 32'hf]) << (4*j));
    return (s << 11) | (s >> 21);
  endfunction

  function automatic logic [63:0] gost_ref(logic [63:0] blk,
                                           logic [255:0] k,
                                           logic dec);
    logic [31:0] a, b, t;
    int ki;
    a = blk[31:0];
    b = blk[63:32];
    for (int r = 0; r < 32; r++) begin
      if (dec ? (r < 8) : (r < 24)) ki = r % 8;
      else ki = 7 - (r % 8);
      t = b ^ f_ref(a + k[32*ki +: 32]);
      b = a;
      a = t;
    end
    return {a, b};
  endfunction

  function automatic logic [255:0] rnd_key();
    logic [255:0] k;
    for (int i = 0; i < 8; i++) k[32*i +: 32] = $urandom;
    return k;
  endfunction

  // Output monitor: latency on each rising valid, data on handshake
  logic ov_q = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      ov_q = 1'b0;
    end else begin
      if (bus.out_valid && !ov_q) begin
        if (exp_q.size() == 0) chk("spurious_valid", 1, 0);
        else chk("latency", 64'(cyc - exp_q[0].cap), 32);
      end
      ov_q = bus.out_valid;
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          chk("spurious_out", 1, 0);
        end else begin
          sb_t e;
          e = exp_q.pop_front();
          chk("out", bus.out_data, e.exp);
        end
      end
    end
  end

  task automatic send(logic [63:0] blk, logic [255:0] k,
                      logic dec, logic [63:0] exp);
    bit ok;
    ok = 1'b0;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b1;
    bus.in_data  = blk;
    bus.key      = k;
    bus.decrypt  = dec;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        exp_q.push_back('{exp: exp, cap: cyc + 1});
        ok = 1'b1;
      end
    end
    if (!ok) chk("in_ready_timeout", 0, 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 300 && exp_q.size() != 0; i++)
      @(negedge clk);
    chk("drain", 64'(exp_q.size()), 0);
  endtask

  task automatic sweep_vec(logic [63:0] p, logic [255:0] k,
                           logic d);
    logic [63:0] e;
    int seen [6];
    int cap;
    e = gost_ref(p, k, d);
    for (int g = 0; g < 6; g++) seen[g] = 0;
    @(posedge clk);
    #1;
    sw_valid = 1'b1;
    sw_in    = p;
    sw_key   = k;
    sw_dec   = d;
    @(negedge clk);
    chk("sw_in_ready", 64'(sw_rdy), 64'h3f);
    cap = cyc + 1;
    @(posedge clk);
    #1;
    sw_valid = 1'b0;
    for (int c = 0; c < 36; c++) begin
      @(negedge clk);
      for (int g = 0; g < 6; g++) begin
        if (sw_ov[g]) begin
          seen[g]++;
          chk($sformatf("sw_out_u%0d", UV[g]), sw_out[g], e);
          chk($sformatf("sw_lat_u%0d", UV[g]),
              64'(cyc - cap), 64'(32 / UV[g]));
        end
      end
    end
    for (int g = 0; g < 6; g++)
      chk($sformatf("sw_count_u%0d", UV[g]), 64'(seen[g]), 1);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0]  ct;
    logic [63:0]  p;
    logic [63:0]  held;
    logic [255:0] k;
    logic [63:0]  p2;
    logic [255:0] k2;
    int           busy_n;
    bit           seen_ov;

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.key       = '0;
    bus.decrypt   = 1'b0;
    bus.out_ready = 1'b1;
    sw_valid      = 1'b0;
    sw_in         = '0;
    sw_key        = '0;
    sw_dec        = 1'b0;

    #3;
    chk("rst_in_ready", 64'(bus.in_ready), 1);
    chk("rst_out_valid", 64'(bus.out_valid), 0);
    chk("rst_out", bus.out_data, 0);
    chk("rst_busy", 64'(bus.busy), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reference vector, then busy span and round trip
    ct = gost_ref(P0, K0, 1'b0);
    send(P0, K0, 1'b0, ct);
    busy_n = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.busy) busy_n++;
    end
    chk("busy_cycles", 64'(busy_n), 32);
    wait_drain();
    send(ct, K0, 1'b1, P0);
    wait_drain();

    // Random round trips, back-to-back through DONE
    for (int i = 0; i < 200; i++) begin
      p  = {$urandom, $urandom};
      k  = rnd_key();
      ct = gost_ref(p, k, 1'b0);
      send(p, k, 1'b0, ct);
      send(ct, k, 1'b1, p);
    end
    wait_drain();

    // Backpressure, then capture on the release cycle
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    p  = {$urandom, $urandom};
    k  = rnd_key();
    send(p, k, 1'b0, gost_ref(p, k, 1'b0));
    seen_ov = 1'b0;
    for (int i = 0; i < 60 && !seen_ov; i++) begin
      @(negedge clk);
      seen_ov = bus.out_valid;
    end
    chk("bp_valid_seen", 64'(seen_ov), 1);
    held = bus.out_data;
    p2 = {$urandom, $urandom};
    k2 = rnd_key();
    @(posedge clk);
    #1;
    bus.in_valid = 1'b1;
    bus.in_data  = p2;
    bus.key      = k2;
    bus.decrypt  = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_valid", 64'(bus.out_valid), 1);
      chk("bp_out", bus.out_data, held);
      chk("bp_in_ready", 64'(bus.in_ready), 0);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("b2b_in_ready", 64'(bus.in_ready), 1);
    exp_q.push_back('{exp: gost_ref(p2, k2, 1'b0), cap: cyc + 1});
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("b2b_busy", 64'(bus.busy), 1);
    wait_drain();

    // Input churn during RUN must not reach the block in flight
    p = {$urandom, $urandom};
    k = rnd_key();
    send(p, k, 1'b1, gost_ref(p, k, 1'b1));
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      bus.in_data  = {$urandom, $urandom};
      bus.key      = rnd_key();
      bus.decrypt  = 1'($urandom);
      bus.in_valid = (i < 20) ? 1'($urandom) : 1'b0;
    end
    wait_drain();

    // Reset at round 17, then a clean block
    p = {$urandom, $urandom};
    k = rnd_key();
    send(p, k, 1'b0, gost_ref(p, k, 1'b0));
    repeat (17) @(posedge clk);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("mid_rst_valid", 64'(bus.out_valid), 0);
    chk("mid_rst_in_ready", 64'(bus.in_ready), 1);
    chk("mid_rst_busy", 64'(bus.busy), 0);
    chk("mid_rst_out", bus.out_data, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    send(P0, K0, 1'b0, gost_ref(P0, K0, 1'b0));
    wait_drain();

    // UNROLL sweep on shared vectors
    sweep_vec(P0, K0, 1'b0);
    for (int i = 0; i < 100; i++)
      sweep_vec({$urandom, $urandom}, rnd_key(), 1'($urandom));

    $display("CHECKS %0d ERRORS %0d", chks, errs);
    $finish;
  end
endmodule
